// File: rtl/bicubic_out_serializer.sv
// ----------------------------------------------------------------------------
// bicubic_out_serializer
//
// Purpose
//   Converts 4-pixel beats from the bicubic upsampler into a one-pixel-per-
//   cycle stream with frame position flags. A single holding register holds
//   one beat. A 2-bit sub-index picks the pixel to present. The next beat can
//   be loaded in the same cycle as the last pixel of the current beat
//   leaves, so a continuous input keeps the output busy with no gaps.
//   Column and row counters track the frame position. They drive the
//   start-of-frame, end-of-line and end-of-frame flags.
//
// Parameters
//   CHANNEL_WIDTH  bits per pixel channel
//   BEATS_PER_ROW  4-pixel input beats per output row
//   DST_HEIGHT     output rows per frame
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   bcci_rsp_valid / bf_rsp_ready   input beat handshake
//   bcci_rsp_data1..4               four adjacent pixels, data1 leftmost
//   ac_data / ac_valid / ac_ready   serialized pixel handshake
//   ac_sof, ac_eol, ac_eof          frame start, line end, frame end flags
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module bicubic_out_serializer #(
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned BEATS_PER_ROW = 960,
    parameter int unsigned DST_HEIGHT    = 2160
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bcci_rsp_valid,
    output logic                     bf_rsp_ready,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
    input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
    output logic [CHANNEL_WIDTH-1:0] ac_data,
    output logic                     ac_valid,
    input  logic                     ac_ready,
    output logic                     ac_sof,
    output logic                     ac_eol,
    output logic                     ac_eof
);

    localparam int unsigned ROW_PIXELS = 4 * BEATS_PER_ROW;
    localparam int unsigned COL_W      = $clog2(ROW_PIXELS) + 1;
    localparam int unsigned ROW_W      = $clog2(DST_HEIGHT) + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_HEIGHT - 1);

    // Element 0 holds data1 (the leftmost pixel), so sub indexes directly.
    logic [3:0][CHANNEL_WIDTH-1:0] hold_q;
    logic                          full_q;
    logic [1:0]                    sub_q;
    logic [COL_W-1:0]              col_q;
    logic [ROW_W-1:0]              row_q;

    logic in_hs;
    logic out_hs;
    logic last_sub;
    logic col_last;
    logic row_last;

    assign out_hs   = full_q & ac_ready;
    assign last_sub = (sub_q == 2'd3);
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // A new beat is accepted in the cycle the last held pixel leaves. This
    // keeps the stream gap-free. The path from ac_ready is combinational.
    assign bf_rsp_ready = ~full_q | (last_sub & out_hs);
    assign in_hs        = bcci_rsp_valid & bf_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the holding register is reset as well. ac_data then
            // reads 0 during reset, not leftover pixel data.
            hold_q <= '0;
            full_q <= 1'b0;
            sub_q  <= 2'd0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignments. Every register
            // then sees the pre-edge values of the others. The full/sub
            // handover when a beat arrives and leaves together relies on it.
            if (in_hs) begin
                hold_q <= {bcci_rsp_data4, bcci_rsp_data3,
                           bcci_rsp_data2, bcci_rsp_data1};
            end

            // Loading wins over draining. A beat that arrives with the last
            // pixel keeps the register full.
            if (in_hs) begin
                full_q <= 1'b1;
            end else if (out_hs && last_sub) begin
                full_q <= 1'b0;
            end

            if (out_hs) begin
                sub_q <= sub_q + 2'd1;  // 3 -> 0 wraps naturally
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: each output gets a value before any conditional logic. No
        // path can then leave one unassigned and infer a latch.
        ac_data  = hold_q[sub_q];
        ac_valid = full_q;
        ac_sof   = full_q & (col_q == '0) & (row_q == '0);
        ac_eol   = full_q & col_last;
        ac_eof   = full_q & col_last & row_last;
    end

endmodule

// File: tb/tb_bicubic_out_serializer.sv
// ----------------------------------------------------------------------------
// tb_bicubic_out_serializer
//
// Directed and randomized bench for bicubic_out_serializer with
// BEATS_PER_ROW=2 (8 pixels/row) and DST_HEIGHT=3 (24 pixels/frame).
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well
// away from the rising edge. The random scenario keeps its own pixel queue
// and frame position.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bicubic_out_serializer;

    localparam int CW  = 8;
    localparam int BPR = 2;
    localparam int DH  = 3;
    localparam int ROW_PX   = 4 * BPR;
    localparam int FRAME_PX = ROW_PX * DH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bcci_rsp_valid = 1'b0;
    logic          bf_rsp_ready;
    logic [CW-1:0] bcci_rsp_data1 = '0;
    logic [CW-1:0] bcci_rsp_data2 = '0;
    logic [CW-1:0] bcci_rsp_data3 = '0;
    logic [CW-1:0] bcci_rsp_data4 = '0;
    logic [CW-1:0] ac_data;
    logic          ac_valid;
    logic          ac_ready = 1'b0;
    logic          ac_sof;
    logic          ac_eol;
    logic          ac_eof;

    // {valid, sof, eol, eof, ready} compared as one vector.
    logic [4:0] status;
    assign status = {ac_valid, ac_sof, ac_eol, ac_eof, bf_rsp_ready};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bicubic_out_serializer #(
        .CHANNEL_WIDTH(CW),
        .BEATS_PER_ROW(BPR),
        .DST_HEIGHT   (DH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bcci_rsp_valid(bcci_rsp_valid),
        .bf_rsp_ready  (bf_rsp_ready),
        .bcci_rsp_data1(bcci_rsp_data1),
        .bcci_rsp_data2(bcci_rsp_data2),
        .bcci_rsp_data3(bcci_rsp_data3),
        .bcci_rsp_data4(bcci_rsp_data4),
        .ac_data       (ac_data),
        .ac_valid      (ac_valid),
        .ac_ready      (ac_ready),
        .ac_sof        (ac_sof),
        .ac_eol        (ac_eol),
        .ac_eof        (ac_eof)
    );

    function automatic logic [31:0] mk_beat(input int a, input int b,
                                            input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Used at a falling edge. Sets the inputs, then waits 1 ns for sampling.
    task automatic drive(input logic v, input logic [31:0] beat, input logic r);
        bcci_rsp_valid = v;
        {bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1} = beat;
        ac_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Beat k of a ramp carries pixels 4k+1 .. 4k+4.
    function automatic logic [31:0] ramp_beat(input int k);
        return mk_beat(4*k+1, 4*k+2, 4*k+3, 4*k+4);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hA5A5A5A5, 1'b1);
            n_checks++;
            if (status !== 5'b00001) begin
                n_fail++;
                $display("FAIL reset_status[%0d]: got %b expected %b", i, status, 5'b00001);
            end
            n_checks++;
            if (ac_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got %h expected %h", i, ac_data, 8'h00);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [4:0] exp_st;
        do_reset();
        drive(1'b1, mk_beat('h10, 'h20, 'h30, 'h40), 1'b1);
        n_checks++;
        if (status !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_accept: got %b expected %b", status, 5'b00001);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1);
            exp_st = {1'b1, k == 0, 1'b0, 1'b0, k == 3};
            n_checks++;
            if (status !== exp_st) begin
                n_fail++;
                $display("FAIL single_status[%0d]: got %b expected %b", k, status, exp_st);
            end
            n_checks++;
            if (ac_data !== 8'(16 * (k + 1))) begin
                n_fail++;
                $display("FAIL single_data[%0d]: got %h expected %h", k, ac_data, 8'(16 * (k + 1)));
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (status !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_drained: got %b expected %b", status, 5'b00001);
        end
        @(negedge clk);
    endtask

    // Valid is held high for the whole frame. Between handover cycles it
    // carries 0xEE junk, which must never be accepted.
    task automatic test_streaming();
        logic [4:0] exp_st;
        logic       ev;
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c < 24)
                drive(1'b1, (c % 4 == 0) ? ramp_beat(c / 4) : 32'hEEEEEEEE, 1'b1);
            else
                drive(1'b0, 32'h0, 1'b1);
            ev     = (c >= 1) && (c <= 24);
            exp_st = {ev, c == 1, ev && (c % 8 == 0), c == 24, (c % 4 == 0) || (c == 25)};
            n_checks++;
            if (status !== exp_st) begin
                n_fail++;
                $display("FAIL stream_status[c%0d]: got %b expected %b", c, status, exp_st);
            end
            if (ev) begin
                n_checks++;
                if (ac_data !== 8'(c)) begin
                    n_fail++;
                    $display("FAIL stream_data[c%0d]: got %h expected %h", c, ac_data, 8'(c));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_st;
        int         exp_d;
        do_reset();
        drive(1'b1, mk_beat(1, 2, 3, 4), 1'b1);
        @(negedge clk);
        // c1..c2: pixels 1 and 2. c3..c7: stalled on pixel 3. c8: pixel 3
        // leaves. c9: pixel 4 plus the next beat. c10..c13: pixels 5..8.
        for (int c = 1; c <= 13; c++) begin
            if (c >= 3 && c <= 7)
                drive(1'b1, 32'hEEEEEEEE, 1'b0);
            else if (c == 8)
                drive(1'b1, 32'hEEEEEEEE, 1'b1);
            else if (c == 9)
                drive(1'b1, mk_beat(5, 6, 7, 8), 1'b1);
            else
                drive(1'b0, 32'h0, 1'b1);
            exp_d  = (c <= 2) ? c : (c <= 8) ? 3 : c - 5;
            exp_st = {1'b1, c == 1, c == 13, 1'b0, (c == 9) || (c == 13)};
            n_checks++;
            if (status !== exp_st) begin
                n_fail++;
                $display("FAIL bp_status[c%0d]: got %b expected %b", c, status, exp_st);
            end
            n_checks++;
            if (ac_data !== 8'(exp_d)) begin
                n_fail++;
                $display("FAIL bp_data[c%0d]: got %h expected %h", c, ac_data, 8'(exp_d));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frame_wrap();
        logic [4:0] exp_st;
        do_reset();
        for (int c = 0; c <= 29; c++) begin
            drive(c < 28, (c % 4 == 0) ? ramp_beat(c / 4) : 32'hEEEEEEEE, 1'b1);
            if (c == 24 || c == 25 || c == 29) begin
                exp_st = (c == 24) ? 5'b10111 : (c == 25) ? 5'b11000 : 5'b00001;
                n_checks++;
                if (status !== exp_st) begin
                    n_fail++;
                    $display("FAIL wrap_status[c%0d]: got %b expected %b", c, status, exp_st);
                end
                if (c != 29) begin
                    n_checks++;
                    if (ac_data !== 8'(c)) begin
                        n_fail++;
                        $display("FAIL wrap_data[c%0d]: got %h expected %h", c, ac_data, 8'(c));
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            drive(1'b1, (c % 4 == 0) ? ramp_beat(c / 4) : 32'hEEEEEEEE, 1'b1);
            if (c < 10) @(negedge clk);
        end
        // c10 presents pixel 10, which is sub 1 of beat 3.
        n_checks++;
        if (ac_data !== 8'd10 || status !== 5'b10000) begin
            n_fail++;
            $display("FAIL midrst_before: got data %h status %b expected data %h status %b",
                     ac_data, status, 8'd10, 5'b10000);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (status !== 5'b00001) begin
            n_fail++;
            $display("FAIL midrst_status: got %b expected %b", status, 5'b00001);
        end
        n_checks++;
        if (ac_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_data: got %h expected %h", ac_data, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, mk_beat('h61, 'h62, 'h63, 'h64), 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (status !== 5'b11000 || ac_data !== 8'h61) begin
            n_fail++;
            $display("FAIL midrst_first: got data %h status %b expected data %h status %b",
                     ac_data, status, 8'h61, 5'b11000);
        end
        @(negedge clk);
    endtask

    // Random valid/ready for 100 frames, checked against a pixel queue and
    // a pixel counter that gives the frame position.
    task automatic test_random();
        logic [CW-1:0] q[$];
        logic [4:0]    exp_st;
        logic [31:0]   beat;
        logic          v;
        logic          r;
        logic          ev;
        logic          er;
        int            pix;
        int            pos;
        int            cycles;
        do_reset();
        pix    = 0;
        cycles = 0;
        while (pix < 100 * FRAME_PX && cycles < 30000) begin
            v    = 1'($urandom_range(0, 1));
            r    = 1'($urandom_range(0, 1));
            beat = $urandom();
            drive(v, beat, r);
            pos    = pix % FRAME_PX;
            ev     = (q.size() != 0);
            er     = (q.size() == 0) || (q.size() == 1 && r);
            exp_st = {ev, ev && pos == 0, ev && (pos % ROW_PX == ROW_PX - 1),
                      ev && pos == FRAME_PX - 1, er};
            n_checks++;
            if (status !== exp_st) begin
                n_fail++;
                $display("FAIL rand_status[pix%0d]: got %b expected %b", pix, status, exp_st);
            end
            if (ev) begin
                n_checks++;
                if (ac_data !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data[pix%0d]: got %h expected %h", pix, ac_data, q[0]);
                end
                if (r) begin
                    void'(q.pop_front());
                    pix++;
                end
            end
            if (v && er) begin
                for (int i = 0; i < 4; i++) q.push_back(beat[8*i +: 8]);
            end
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (pix < 100 * FRAME_PX) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d pixels expected %0d", pix, 100 * FRAME_PX);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_streaming();
        test_backpressure();
        test_frame_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
